// File: rtl/edge_scoreboard_mc.sv
// Multi-channel edge scoreboard: counts rise/fall strobes per channel and matches
// them in order against a queue of expected edges, each within a WIN-cycle window.
module edge_scoreboard_mc #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIN   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NCH-1:0]         rise_obs,
  input  logic [NCH-1:0]         fall_obs,
  input  logic                   exp_valid,
  output logic                   exp_ready,
  input  logic [$clog2(NCH)-1:0] exp_ch,
  input  logic                   exp_pol,
  input  logic                   report_req,
  output logic [NCH*CNT_W-1:0]   rise_cnt,
  output logic [NCH*CNT_W-1:0]   fall_cnt,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [CNT_W-1:0]       miss_cnt,
  output logic [CNT_W-1:0]       unexp_cnt,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   err
);

  localparam int unsigned CH_W  = $clog2(NCH);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned PC_W  = $clog2(2 * NCH + 1);
  localparam int unsigned SUM_W = CNT_W + PC_W;
  localparam int unsigned AGE_W = (WIN > 1) ? $clog2(WIN) : 1;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            pol;
  } exp_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  exp_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  state_t           state;
  logic [AGE_W-1:0] age;
  logic [CNT_W-1:0] rise_q [NCH];
  logic [CNT_W-1:0] fall_q [NCH];

  exp_t             head;
  logic             hit;
  logic             timeout;
  logic             pop;
  logic             push;
  logic [PC_W-1:0]  obs;
  logic [PC_W-1:0]  unexp_add;
  logic [PW-1:0]    pending_nx;

  // Saturating add; the sum is wide enough that a multi-edge increment cannot wrap.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return (s[SUM_W-1:CNT_W] != '0) ? '1 : s[CNT_W-1:0];
  endfunction

  // Head compare, timeout, and this cycle's unexpected-edge count.
  always_comb begin
    head    = mem[rd_ptr];
    hit     = 1'b0;
    obs     = '0;
    if (enable && state == S_WAIT)
      hit = head.pol ? rise_obs[head.ch] : fall_obs[head.ch];
    timeout = enable && (state == S_WAIT) && !hit && (age == AGE_W'(WIN - 1));
    pop     = hit | timeout;
    push    = exp_valid & exp_ready;
    if (enable) begin
      for (int i = 0; i < NCH; i++)
        obs = obs + PC_W'(rise_obs[i]) + PC_W'(fall_obs[i]);
    end
    unexp_add  = obs - PC_W'(hit);
    pending_nx = pending + PW'(push) - PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset && push)
      mem[wr_ptr] <= '{ch: exp_ch, pol: exp_pol};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pending   <= '0;
      exp_ready <= 1'b1;
      state     <= S_IDLE;
      age       <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      unexp_cnt <= '0;
      err       <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        rise_q[i] <= '0;
        fall_q[i] <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      pending   <= pending_nx;
      exp_ready <= (pending_nx != PW'(DEPTH));

      case (state)
        S_IDLE: if (pending_nx != '0) state <= S_WAIT;
        S_WAIT: if (pending_nx == '0) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Age restarts for every new head and holds while disabled.
      if (pop)
        age <= '0;
      else if (enable && state == S_WAIT)
        age <= age + AGE_W'(1);

      if (enable) begin
        for (int i = 0; i < NCH; i++) begin
          rise_q[i] <= sat_add(rise_q[i], PC_W'(rise_obs[i]));
          fall_q[i] <= sat_add(fall_q[i], PC_W'(fall_obs[i]));
        end
      end
      match_cnt <= sat_add(match_cnt, PC_W'(hit));
      miss_cnt  <= sat_add(miss_cnt, PC_W'(timeout));
      unexp_cnt <= sat_add(unexp_cnt, unexp_add);
      if (timeout || unexp_add != '0) err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign rise_cnt[g*CNT_W +: CNT_W] = rise_q[g];
    assign fall_cnt[g*CNT_W +: CNT_W] = fall_q[g];
  end

`ifndef SYNTHESIS
  logic report_q;

  // Summary print, once on the first sampled-high cycle of each request pulse.
  always_ff @(posedge clk) begin
    if (!reset) report_q <= 1'b0;
    else        report_q <= report_req;
    if (report_req && !report_q) begin
      $display("edge_scoreboard_mc report: match=%0d miss=%0d unexp=%0d pending=%0d",
               match_cnt, miss_cnt, unexp_cnt, pending);
      for (int i = 0; i < NCH; i++)
        $display("edge_scoreboard_mc report: ch%0d rise=%0d fall=%0d", i, rise_q[i], fall_q[i]);
    end
  end
`endif

endmodule

// File: tb/tb_edge_scoreboard_mc.sv
// Bench for edge_scoreboard_mc: behavioural model feeding a one-cycle scoreboard,
// a vector table for empty-FIFO strobes, and hand sequences for window/FIFO corners.
module tb_edge_scoreboard_mc;

  localparam int NCH = 4, DEPTH = 8, WIN = 16, MAX = 65535;

  logic        clk = 1'b0;
  logic        reset, enable, exp_valid, exp_pol, report_req;
  logic [3:0]  rise_obs, fall_obs;
  logic [1:0]  exp_ch;
  logic        exp_ready, err;
  logic [63:0] rise_cnt, fall_cnt;
  logic [15:0] match_cnt, miss_cnt, unexp_cnt;
  logic [3:0]  pending;
  logic        s_exp_ready, s_err;
  logic [15:0] s_rise_cnt, s_fall_cnt;
  logic [3:0]  s_match_cnt, s_miss_cnt, s_unexp_cnt, s_pending;

  always #5 clk = ~clk;

  edge_scoreboard_mc #(.NCH(4), .CNT_W(16), .DEPTH(8), .WIN(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rise_obs(rise_obs), .fall_obs(fall_obs),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_ch(exp_ch), .exp_pol(exp_pol),
    .report_req(report_req), .rise_cnt(rise_cnt), .fall_cnt(fall_cnt),
    .match_cnt(match_cnt), .miss_cnt(miss_cnt), .unexp_cnt(unexp_cnt),
    .pending(pending), .err(err)
  );

  edge_scoreboard_mc #(.NCH(4), .CNT_W(4), .DEPTH(8), .WIN(16)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .rise_obs(rise_obs), .fall_obs(fall_obs),
    .exp_valid(exp_valid), .exp_ready(s_exp_ready), .exp_ch(exp_ch), .exp_pol(exp_pol),
    .report_req(1'b0), .rise_cnt(s_rise_cnt), .fall_cnt(s_fall_cnt),
    .match_cnt(s_match_cnt), .miss_cnt(s_miss_cnt), .unexp_cnt(s_unexp_cnt),
    .pending(s_pending), .err(s_err)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       ev;
    logic [1:0] ch;
    logic       pol;
    logic       rep;
  } vin_t;

  typedef struct {
    vin_t in;
    int   unexp_tot;
    int   rise0;
    int   fall0;
  } vec_t;

  typedef struct {
    logic [63:0] rise;
    logic [63:0] fall;
    logic [15:0] match;
    logic [15:0] miss;
    logic [15:0] unexp;
    logic [3:0]  pend;
    logic        err;
    logic        rdy;
  } snap_t;

  typedef struct {
    int ch;
    bit pol;
  } ent_t;

  int    n_checks = 0;
  int    n_err = 0;
  snap_t sb[$];
  ent_t  mq[$];
  int    m_rise[NCH], m_fall[NCH];
  int    m_match, m_miss, m_unexp, m_age;
  bit    m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > MAX) ? MAX : x;
  endfunction

  function automatic vin_t mk(input bit rst_n, input bit en, input logic [3:0] rise,
                              input logic [3:0] fall, input bit ev, input int ch, input bit pol);
    vin_t v;
    v.rst_n = rst_n; v.en = en; v.rise = rise; v.fall = fall;
    v.ev = ev; v.ch = 2'(ch); v.pol = pol; v.rep = 1'b0;
    return v;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.rise = '0;
    s.fall = '0;
    for (int i = 0; i < NCH; i++) begin
      s.rise[i*16 +: 16] = 16'(m_rise[i]);
      s.fall[i*16 +: 16] = 16'(m_fall[i]);
    end
    s.match = 16'(m_match);
    s.miss  = 16'(m_miss);
    s.unexp = 16'(m_unexp);
    s.pend  = 4'(mq.size());
    s.err   = m_err;
    s.rdy   = (mq.size() != DEPTH);
    return s;
  endfunction

  // Advance the model one clock for the given inputs.
  task automatic model_update(input vin_t v);
    bit   push, hit, tmo;
    int   add;
    ent_t e;
    if (!v.rst_n) begin
      for (int i = 0; i < NCH; i++) begin m_rise[i] = 0; m_fall[i] = 0; end
      m_match = 0; m_miss = 0; m_unexp = 0; m_age = 0; m_err = 0;
      mq.delete();
      return;
    end
    push = v.ev && (mq.size() != DEPTH);
    hit  = 0;
    tmo  = 0;
    if (v.en && mq.size() != 0) begin
      hit = mq[0].pol ? v.rise[mq[0].ch] : v.fall[mq[0].ch];
      tmo = !hit && (m_age == WIN - 1);
    end
    add = 0;
    if (v.en) begin
      for (int i = 0; i < NCH; i++) begin
        add += int'(v.rise[i]) + int'(v.fall[i]);
        m_rise[i] = sat(m_rise[i] + int'(v.rise[i]));
        m_fall[i] = sat(m_fall[i] + int'(v.fall[i]));
      end
    end
    add -= int'(hit);
    m_unexp = sat(m_unexp + add);
    m_match = sat(m_match + int'(hit));
    m_miss  = sat(m_miss + int'(tmo));
    if (tmo || add != 0) m_err = 1;
    if (hit || tmo) begin
      void'(mq.pop_front());
      m_age = 0;
    end else if (v.en && mq.size() != 0) begin
      m_age++;
    end
    if (push) begin
      e.ch = int'(v.ch);
      e.pol = v.pol;
      mq.push_back(e);
    end
  endtask

  // Drive one cycle, queue the model's expectation, compare after the edge.
  task automatic step(input vin_t v);
    snap_t s;
    @(negedge clk);
    reset = v.rst_n; enable = v.en; rise_obs = v.rise; fall_obs = v.fall;
    exp_valid = v.ev; exp_ch = v.ch; exp_pol = v.pol; report_req = v.rep;
    model_update(v);
    sb.push_back(model_snap());
    @(posedge clk);
    #1;
    s = sb.pop_front();
    chk("rise_cnt", rise_cnt, s.rise);
    chk("fall_cnt", fall_cnt, s.fall);
    chk("match_cnt", 64'(match_cnt), 64'(s.match));
    chk("miss_cnt", 64'(miss_cnt), 64'(s.miss));
    chk("unexp_cnt", 64'(unexp_cnt), 64'(s.unexp));
    chk("pending", 64'(pending), 64'(s.pend));
    chk("err", 64'(err), 64'(s.err));
    chk("exp_ready", 64'(exp_ready), 64'(s.rdy));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(mk(1, 1, 4'h0, 4'h0, 0, 0, 0));
  endtask

  task automatic push_e(input int ch, input bit pol);
    step(mk(1, 1, 4'h0, 4'h0, 1, ch, pol));
  endtask

  task automatic do_reset();
    step(mk(0, 1, 4'h0, 4'h0, 0, 0, 0));
    step(mk(0, 1, 4'h0, 4'h0, 0, 0, 0));
  endtask

  function automatic logic [3:0] onehot(input int ch);
    logic [3:0] b;
    b = 4'b0001;
    return b << ch;
  endfunction

  vec_t vtab[5];
  vin_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; rise_obs = '0; fall_obs = '0;
    exp_valid = 1'b0; exp_ch = '0; exp_pol = 1'b0; report_req = 1'b0;

    vtab[0] = '{mk(1, 1, 4'b0101, 4'b0001, 0, 0, 0), 3, 1, 1};
    vtab[1] = '{mk(1, 0, 4'b0101, 4'b0001, 0, 0, 0), 3, 1, 1};
    vtab[2] = '{mk(1, 1, 4'b1111, 4'b1111, 0, 0, 0), 11, 2, 2};
    vtab[3] = '{mk(1, 1, 4'b0000, 4'b1000, 0, 0, 0), 12, 2, 2};
    vtab[4] = '{mk(1, 0, 4'b1111, 4'b0000, 1, 2, 1), 12, 2, 2};

    // Reset state
    do_reset();
    idle(1);
    chk("t1 pending", 64'(pending), 64'd0);
    chk("t1 exp_ready", 64'(exp_ready), 64'd1);
    chk("t1 err", 64'(err), 64'd0);
    chk("t1 counts", rise_cnt | fall_cnt, 64'd0);

    // Single match, with a disabled look-alike strobe first
    do_reset();
    push_e(2, 1);
    step(mk(1, 0, 4'b0100, 4'b0000, 0, 0, 0));
    idle(1);
    step(mk(1, 1, 4'b0100, 4'b0000, 0, 0, 0));
    chk("t2 match_cnt", 64'(match_cnt), 64'd1);
    chk("t2 rise ch2", 64'(rise_cnt[32 +: 16]), 64'd1);
    chk("t2 pending", 64'(pending), 64'd0);
    chk("t2 err", 64'(err), 64'd0);

    // Timeout after exactly WIN eligible cycles, then an unexpected edge
    do_reset();
    push_e(1, 0);
    idle(15);
    chk("t3 miss early", 64'(miss_cnt), 64'd0);
    chk("t3 pending early", 64'(pending), 64'd1);
    idle(1);
    chk("t3 miss_cnt", 64'(miss_cnt), 64'd1);
    chk("t3 pending", 64'(pending), 64'd0);
    chk("t3 err", 64'(err), 64'd1);
    step(mk(1, 1, 4'b0000, 4'b0010, 0, 0, 0));
    chk("t3 unexp_cnt", 64'(unexp_cnt), 64'd1);

    // Match on the last cycle of the window
    do_reset();
    push_e(3, 1);
    idle(15);
    step(mk(1, 1, 4'b1000, 4'b0000, 0, 0, 0));
    chk("t3b match last", 64'(match_cnt), 64'd1);
    chk("t3b no miss", 64'(miss_cnt), 64'd0);

    // Age holds while disabled
    do_reset();
    push_e(0, 0);
    idle(10);
    for (int k = 0; k < 10; k++) step(mk(1, 0, 4'h0, 4'h0, 0, 0, 0));
    idle(5);
    chk("t3c frozen no miss", 64'(miss_cnt), 64'd0);
    idle(1);
    chk("t3c miss", 64'(miss_cnt), 64'd1);

    // Empty-FIFO strobe table
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(vtab[k].in);
      chk($sformatf("t4[%0d] unexp", k), 64'(unexp_cnt), 64'(vtab[k].unexp_tot));
      chk($sformatf("t4[%0d] rise0", k), 64'(rise_cnt[15:0]), 64'(vtab[k].rise0));
      chk($sformatf("t4[%0d] fall0", k), 64'(fall_cnt[15:0]), 64'(vtab[k].fall0));
    end

    // Fill, drop on full, out-of-order strobe, in-order drain
    do_reset();
    for (int k = 0; k < 8; k++) push_e(k % 4, (k % 2) == 0);
    chk("t5 full ready", 64'(exp_ready), 64'd0);
    chk("t5 full pending", 64'(pending), 64'd8);
    push_e(3, 1);
    chk("t5 drop pending", 64'(pending), 64'd8);
    step(mk(1, 1, 4'b0000, 4'b0010, 0, 0, 0));
    chk("t5 ooo unexp", 64'(unexp_cnt), 64'd1);
    chk("t5 ooo match", 64'(match_cnt), 64'd0);
    chk("t5 ooo pending", 64'(pending), 64'd8);
    rv = mk(1, 1, 4'h0, 4'h0, 0, 0, 0);
    rv.rep = 1'b1;
    step(rv);
    for (int k = 0; k < 8; k++) begin
      bit pol;
      pol = (k % 2) == 0;
      rv = mk(1, 1, pol ? onehot(k % 4) : 4'h0, pol ? 4'h0 : onehot(k % 4), k == 0, 1, 1);
      step(rv);
      if (k == 0) chk("t5 pop+full push", 64'(pending), 64'd7);
    end
    chk("t5 match_cnt", 64'(match_cnt), 64'd8);
    chk("t5 pending", 64'(pending), 64'd0);
    chk("t5 ready", 64'(exp_ready), 64'd1);
    chk("t5 miss", 64'(miss_cnt), 64'd0);

    // Saturation on the narrow instance, then reset overriding activity
    do_reset();
    for (int k = 0; k < 20; k++) step(mk(1, 1, 4'b0001, 4'b0000, 0, 0, 0));
    chk("t6 sat unexp", 64'(s_unexp_cnt), 64'd15);
    chk("t6 sat rise0", 64'(s_rise_cnt[3:0]), 64'd15);
    chk("t6 sat err", 64'(s_err), 64'd1);
    chk("t6 wide unexp", 64'(unexp_cnt), 64'd20);
    push_e(0, 1); push_e(1, 0); push_e(2, 1);
    chk("t6 pending3", 64'(pending), 64'd3);
    step(mk(0, 1, 4'b1111, 4'b1111, 1, 3, 1));
    chk("t6 rst counts", rise_cnt | fall_cnt, 64'd0);
    chk("t6 rst stats", 64'({match_cnt, miss_cnt, unexp_cnt}), 64'd0);
    chk("t6 rst pending", 64'(pending), 64'd0);
    chk("t6 rst err", 64'(err), 64'd0);
    chk("t6 rst ready", 64'(exp_ready), 64'd1);
    chk("t6 sat rst", 64'({s_rise_cnt, s_fall_cnt, s_unexp_cnt, s_pending, s_err}), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
